reg_dump_reader: RTL and testbench

//  Debug reader for the 8-entry 16-bit register file. On a start pulse it walks the file

---
 rtl/reg_dump_reader.sv | 87 ++++++++
 tb/tb_reg_dump_reader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register file through one read port and streams {addr, data} beats
module reg_dump_reader #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int SKIP_R0  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_start,
    input  logic              dump_abort,
    output logic              dump_busy,
    output logic              dump_done,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    typedef enum logic [1:0] {IDLE, CAPTURE, SEND, DONE} state_t;
    localparam logic [ADDR_W-1:0] FIRST = (SKIP_R0 != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);
    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_idx;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              w_hs;
    logic              w_abort;
    assign w_hs         = r_out_valid && out_ready;
    assign w_abort      = dump_abort && (r_state != IDLE);
    assign dump_busy    = r_state != IDLE;
    assign dump_done    = (r_state == DONE) && !dump_abort;
    assign rf_read_addr = (r_state == CAPTURE || r_state == SEND) ? r_idx : '0;
    assign out_valid    = r_out_valid;
    assign out_addr     = r_out_addr;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // next state: abort from any busy state returns to IDLE and overrides a handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (dump_start && !dump_abort) ? CAPTURE : IDLE;
            CAPTURE: w_next = SEND;
            SEND:    w_next = w_hs ? (r_out_last ? DONE : CAPTURE) : SEND;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end
    // index and beat registers: capture on CAPTURE, hold through SEND until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_abort) begin
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (dump_start && !dump_abort) r_idx <= FIRST;
                CAPTURE: begin
                    r_out_data  <= rf_read_data;
                    r_out_addr  <= r_idx;
                    r_out_last  <= r_idx == LAST;
                    r_out_valid <= 1'b1;
                end
                SEND: if (w_hs) begin
                    r_out_valid <= 1'b0;
                    if (!r_out_last) r_idx <= r_idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: scoreboard bench for reg_dump_reader with a modelled register file
module tb_reg_dump_reader;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    logic start0 = 0, abort0 = 0, ready0 = 0, start1 = 0, abort1 = 0, ready1 = 0;
    logic busy0, done0, valid0, last0, busy1, done1, valid1, last1;
    logic [2:0] ra0, addr0, ra1, addr1;
    logic [15:0] rd0, data0, rd1, data1;
    logic [15:0] rf [8];
    logic we = 0;
    logic [2:0] wa = 0;
    logic [15:0] wd = 0;
    always @(posedge clk) if (we) rf[wa] <= wd;
    assign rd0 = (ra0 == 3'd0) ? 16'h0 : rf[ra0];
    assign rd1 = (ra1 == 3'd0) ? 16'h0 : rf[ra1];

    reg_dump_reader #(.SKIP_R0(1)) u0 (
        .clk(clk), .rst(rst), .dump_start(start0), .dump_abort(abort0), .dump_busy(busy0),
        .dump_done(done0), .rf_read_addr(ra0), .rf_read_data(rd0), .out_valid(valid0),
        .out_ready(ready0), .out_addr(addr0), .out_data(data0), .out_last(last0));
    reg_dump_reader #(.SKIP_R0(0)) u1 (
        .clk(clk), .rst(rst), .dump_start(start1), .dump_abort(abort1), .dump_busy(busy1),
        .dump_done(done1), .rf_read_addr(ra1), .rf_read_data(rd1), .out_valid(valid1),
        .out_ready(ready1), .out_addr(addr1), .out_data(data1), .out_last(last1));

    int n = 0, fails = 0, cyc = 0;
    int done_cnt0 = 0, done_cnt1 = 0, beats0 = 0, beats1 = 0, last_hs0 = -10;
    logic [19:0] q0[$];
    logic [19:0] q1[$];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitors: pop expected beat on every accepted handshake
    always @(negedge clk) begin
        if (valid0 && ready0) begin
            beats0++;
            if (last0) last_hs0 = cyc;
            if (q0.size() == 0) begin
                n++; fails++;
                $display("FAIL beat0: unexpected beat addr=%0d data=%h", addr0, data0);
            end else chk("beat0", {12'h0, last0, addr0, data0}, {12'h0, q0.pop_front()});
        end
        if (done0) done_cnt0++;
    end
    always @(negedge clk) begin
        if (valid1 && ready1) begin
            beats1++;
            if (q1.size() == 0) begin
                n++; fails++;
                $display("FAIL beat1: unexpected beat addr=%0d data=%h", addr1, data1);
            end else chk("beat1", {12'h0, last1, addr1, data1}, {12'h0, q1.pop_front()});
        end
        if (done1) done_cnt1++;
    end

    task automatic push0(input int a, input logic [15:0] d);
        q0.push_back({a == 7, 3'(a), d});
    endtask
    task automatic push_seq0(input int first);
        for (int i = first; i < 8; i++) push0(i, 16'(32'h1111 * i));
    endtask
    task automatic tick;
        @(posedge clk); #1;
    endtask
    task automatic go0;
        tick; start0 = 1; tick; start0 = 0;
    endtask
    task automatic wr(input int a, input logic [15:0] d);
        tick; we = 1; wa = 3'(a); wd = d; tick; we = 0;
    endtask
    task automatic pulse_ready0;
        @(posedge clk); #1 ready0 = 1;
        @(posedge clk); #1 ready0 = 0;
    endtask
    task automatic wait_valid0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (valid0) return;
        end
        n++; fails++;
        $display("FAIL wait_valid0: timeout got 0 required 1");
    endtask
    task automatic wait_done0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done0) return;
        end
        n++; fails++;
        $display("FAIL wait_done0: timeout got 0 required 1");
    endtask
    task automatic wait_done1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done1) return;
        end
        n++; fails++;
        $display("FAIL wait_done1: timeout got 0 required 1");
    endtask

    initial begin
        int dc, b;
        logic [2:0] ha;
        logic [15:0] hd;
        for (int i = 1; i < 8; i++) wr(i, 16'(32'h1111 * i));
        @(negedge clk);
        chk("rst_valid0", valid0, 0); chk("rst_busy0", busy0, 0); chk("rst_done0", done0, 0);
        chk("rst_ra0", ra0, 0); chk("rst_addr0", addr0, 0); chk("rst_data0", data0, 0);
        chk("rst_last0", last0, 0); chk("rst_valid1", valid1, 0);
        tick; rst = 0;
        // 1: full dump at full rate
        ready0 = 1; push_seq0(1); go0; wait_done0;
        chk("done_after_last", cyc, last_hs0 + 1);
        @(negedge clk);
        chk("busy_after_done", busy0, 0); chk("done_one_cycle", done0, 0);
        chk("q0_empty_t1", q0.size(), 0); chk("done_cnt_t1", done_cnt0, 1);
        // 2: back-pressure on addr 3
        ready0 = 0; push_seq0(1); go0;
        for (int k = 1; k <= 7; k++) begin
            wait_valid0;
            if (addr0 == 3'd3) begin
                ha = addr0; hd = data0;
                repeat (5) begin
                    @(negedge clk);
                    chk("hold_valid", valid0, 1); chk("hold_addr", addr0, ha); chk("hold_data", data0, hd);
                end
            end
            pulse_ready0;
        end
        wait_done0; @(negedge clk);
        chk("q0_empty_t2", q0.size(), 0); chk("done_cnt_t2", done_cnt0, 2);
        // 3: abort while addr 4 is valid, then restart
        ready0 = 0; push0(1, 16'h1111); push0(2, 16'h2222); push0(3, 16'h3333); go0;
        repeat (3) begin wait_valid0; pulse_ready0; end
        wait_valid0;
        chk("abort_at4", addr0, 4);
        dc = done_cnt0;
        @(posedge clk); #1 abort0 = 1; tick; abort0 = 0;
        @(negedge clk);
        chk("abort_valid", valid0, 0); chk("abort_busy", busy0, 0);
        repeat (5) tick;
        chk("abort_no_done", done_cnt0, dc);
        ready0 = 1; push_seq0(1); go0; wait_done0; @(negedge clk);
        chk("q0_empty_t3", q0.size(), 0);
        // 4: snapshot timing against writes
        ready0 = 0;
        push0(1, 16'h1111); push0(2, 16'h2222); push0(3, 16'h3333); push0(4, 16'h4444);
        push0(5, 16'hBEEF); push0(6, 16'h6666); push0(7, 16'h7777);
        go0; wait_valid0; pulse_ready0; wait_valid0;
        chk("write_at2", addr0, 2);
        wr(2, 16'hDEAD); wr(5, 16'hBEEF); pulse_ready0;
        repeat (5) begin wait_valid0; pulse_ready0; end
        wait_done0;
        wr(2, 16'h2222); wr(5, 16'h5555);
        chk("q0_empty_t4", q0.size(), 0);
        // 5: starts while busy and in DONE are ignored
        ready0 = 1; push_seq0(1); dc = done_cnt0; b = beats0; go0;
        repeat (4) tick;
        start0 = 1; tick; start0 = 0;
        wait_done0;
        start0 = 1; @(posedge clk); #1 start0 = 0;
        repeat (10) tick;
        @(negedge clk);
        chk("t5_busy", busy0, 0); chk("t5_beats", beats0 - b, 7);
        chk("t5_done", done_cnt0 - dc, 1); chk("q0_empty_t5", q0.size(), 0);
        // 6: async reset mid-beat, then r0-inclusive walk
        ready0 = 0; push_seq0(1); go0; wait_valid0;
        #2 rst = 1; #1;
        chk("arst_valid", valid0, 0); chk("arst_busy", busy0, 0); chk("arst_done", done0, 0);
        chk("arst_addr", addr0, 0); chk("arst_ra", ra0, 0);
        q0.delete();
        tick; rst = 0;
        ready1 = 1;
        for (int i = 0; i < 8; i++) q1.push_back({i == 7, 3'(i), 16'(32'h1111 * i)});
        tick; start1 = 1; tick; start1 = 0;
        wait_done1; @(negedge clk);
        chk("t6_beats", beats1, 8); chk("q1_empty_t6", q1.size(), 0); chk("t6_done", done_cnt1, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n, fails);
        $finish;
    end
endmodule
